bin_to_bcd_seq: RTL and testbench

- Sequential double-dabble binary-to-BCD converter.
- Sits between the CPU's 13-bit ssd value output and the seven-segment display driver, so the display receives decimal digits instead of raw binary.
- Converts one bit per clock with a start/busy/done handshake and holds the last result stable for the display's multiplexing.

---
 rtl/bin_to_bcd_seq_pkg.sv | 14 +
 rtl/bin_to_bcd_seq_if.sv | 21 ++
 rtl/bcd_digit_adjust.sv | 11 +
 rtl/bin_to_bcd_seq.sv | 104 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// rtl/bin_to_bcd_seq_pkg.sv - shared state encoding and BCD constants for bin_to_bcd_seq
package bin_to_bcd_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;
    localparam logic [3:0] SAT_DIGIT  = 4'd9;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/busy/done handshake and result bundle (negative exists with BIN_TO_BCD_SIGNED_EN)
interface bin_to_bcd_seq_if #(
    parameter int IN_W   = 13,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [IN_W-1:0]       bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
`ifdef BIN_TO_BCD_SIGNED_EN
    logic                  negative;

    modport master (output start, bin_in, input busy, done, bcd_out, overflow, negative);
    modport slave  (input start, bin_in, output busy, done, bcd_out, overflow, negative);
`else
    modport master (output start, bin_in, input busy, done, bcd_out, overflow);
    modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);
`endif
endinterface

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - double-dabble "if >=5 add 3" cell for one BCD digit
module bcd_digit_adjust
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q
);

    assign q = (d >= ADJ_THRESH) ? d + ADJ_ADD : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - bit-serial double-dabble converter; BIN_TO_BCD_SIGNED_EN converts |bin_in| and reports sign
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int IN_W   = 13,
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int OUT_W = BCD_W * DIGITS;
    localparam int ACC_W = OUT_W + BCD_W;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    state_t            state;
    logic [IN_W-1:0]   shift_q;
    logic [IN_W-1:0]   load_val;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_adj;
    logic [ACC_W-1:0]  acc_next;
    logic [CNT_W-1:0]  cnt_q;
    logic [OUT_W-1:0]  bcd_next;
    logic              ovf_next;

    genvar g;
    for (g = 0; g <= DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .d (acc_q[g*BCD_W +: BCD_W]),
            .q (acc_adj[g*BCD_W +: BCD_W])
        );
    end

    assign acc_next = {acc_adj[ACC_W-2:0], shift_q[IN_W-1]};

`ifdef BIN_TO_BCD_SIGNED_EN
    logic neg_q;
    assign load_val = bus.bin_in[IN_W-1] ? (~bus.bin_in + IN_W'(1)) : bus.bin_in;
`else
    assign load_val = bus.bin_in;
`endif

    // A bit falling out of the extra digit during the final shift is also an overflow.
    always_comb begin
        ovf_next = acc_adj[ACC_W-1] || (acc_next[ACC_W-1 -: BCD_W] != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_next[i*BCD_W +: BCD_W] > SAT_DIGIT) begin
                ovf_next = 1'b1;
            end
        end
        bcd_next = ovf_next ? {DIGITS{SAT_DIGIT}} : acc_next[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            shift_q      <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.bcd_out  <= '0;
            bus.overflow <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
            neg_q        <= 1'b0;
            bus.negative <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_q  <= load_val;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        bus.busy <= 1'b1;
                        state    <= CONV;
`ifdef BIN_TO_BCD_SIGNED_EN
                        neg_q    <= bus.bin_in[IN_W-1];
`endif
                    end
                end
                CONV: begin
                    acc_q   <= acc_next;
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(IN_W - 1)) begin
                        bus.bcd_out  <= bcd_next;
                        bus.overflow <= ovf_next;
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
`ifdef BIN_TO_BCD_SIGNED_EN
                        bus.negative <= neg_q;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed self-checking bench for bin_to_bcd_seq (13-bit and 14-bit instances)
module tb_bin_to_bcd_seq;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    bin_to_bcd_seq_if #(.IN_W(13), .DIGITS(4)) bus0 ();
    bin_to_bcd_seq_if #(.IN_W(14), .DIGITS(4)) bus1 ();

    bin_to_bcd_seq #(.IN_W(13), .DIGITS(4)) u_dut0 (.clk(clk), .rst(rst_n), .bus(bus0));
    bin_to_bcd_seq #(.IN_W(14), .DIGITS(4)) u_dut1 (.clk(clk), .rst(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run0(input logic [12:0] val, output int lat, output int busy_cyc,
                        output logic [15:0] bcd, output logic ovf);
        @(negedge clk);
        bus0.bin_in = val;
        bus0.start  = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        lat = 0;
        busy_cyc = (bus0.busy === 1'b1) ? 1 : 0;
        while (lat < 40 && bus0.done !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
            if (bus0.busy === 1'b1) busy_cyc++;
        end
        bcd = bus0.bcd_out;
        ovf = bus0.overflow;
    endtask

    task automatic run1(input logic [13:0] val, output int lat,
                        output logic [15:0] bcd, output logic ovf);
        @(negedge clk);
        bus1.bin_in = val;
        bus1.start  = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        lat = 0;
        while (lat < 40 && bus1.done !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
        end
        bcd = bus1.bcd_out;
        ovf = bus1.overflow;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus0.start = 1'b0; bus0.bin_in = '0;
        bus1.start = 1'b0; bus1.bin_in = '0;
        #3;
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus0.busy); end
        checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus0.done); end
        checks++; if (bus0.bcd_out !== 16'h0000) begin errors++; $display("FAIL reset_bcd got=%h exp=0000", bus0.bcd_out); end
        checks++; if (bus0.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus0.overflow); end
        checks++; if (bus1.bcd_out !== 16'h0000) begin errors++; $display("FAIL reset_bcd1 got=%h exp=0000", bus1.bcd_out); end
`ifdef BIN_TO_BCD_SIGNED_EN
        checks++; if (bus0.negative !== 1'b0) begin errors++; $display("FAIL reset_neg got=%b exp=0", bus0.negative); end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [12:0] vals [3];
        logic [15:0] exps [3];
        int          lat, busy_cyc;
        logic [15:0] bcd;
        logic        ovf;
        vals[0] = 13'd8191;
`ifdef BIN_TO_BCD_SIGNED_EN
        exps[0] = 16'h0001;
`else
        exps[0] = 16'h8191;
`endif
        vals[1] = 13'd0;    exps[1] = 16'h0000;
        vals[2] = 13'd1234; exps[2] = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            run0(vals[i], lat, busy_cyc, bcd, ovf);
            checks++; if (lat != 13) begin errors++; $display("FAIL basic_latency[%0d] got=%0d exp=13", i, lat); end
            checks++; if (busy_cyc != 13) begin errors++; $display("FAIL basic_busy_cycles[%0d] got=%0d exp=13", i, busy_cyc); end
            checks++; if (bcd !== exps[i]) begin errors++; $display("FAIL basic_bcd[%0d] got=%h exp=%h", i, bcd, exps[i]); end
            checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf[%0d] got=%b exp=0", i, ovf); end
            @(posedge clk); #1;
            checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse[%0d] got=%b exp=0", i, bus0.done); end
            checks++; if (bus0.bcd_out !== exps[i]) begin errors++; $display("FAIL basic_bcd_hold[%0d] got=%h exp=%h", i, bus0.bcd_out, exps[i]); end
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        @(negedge clk);
        bus0.bin_in = 13'd4095;
        bus0.start  = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        lat = 0;
        while (lat < 40 && bus0.done !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin
                bus0.bin_in = 13'd9;
                bus0.start  = 1'b1;
            end
        end
        checks++; if (lat != 13) begin errors++; $display("FAIL busy_ignore_latency got=%0d exp=13", lat); end
        checks++; if (bus0.bcd_out !== 16'h4095) begin errors++; $display("FAIL busy_ignore_bcd got=%h exp=4095", bus0.bcd_out); end
        @(posedge clk); #1;
        bus0.start = 1'b0;
        checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL busy_single_done got=%b exp=0", bus0.done); end
        checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL done_cycle_start_busy got=%b exp=1", bus0.busy); end
        lat = 0;
        while (lat < 40 && bus0.done !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat != 13) begin errors++; $display("FAIL done_cycle_start_latency got=%0d exp=13", lat); end
        checks++; if (bus0.bcd_out !== 16'h0009) begin errors++; $display("FAIL done_cycle_start_bcd got=%h exp=0009", bus0.bcd_out); end
    endtask

    task automatic test_reset_abort();
        int ndone;
        @(negedge clk);
        bus0.bin_in = 13'd5000;
        bus0.start  = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus0.busy); end
        checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", bus0.done); end
        checks++; if (bus0.bcd_out !== 16'h0000) begin errors++; $display("FAIL abort_bcd got=%h exp=0000", bus0.bcd_out); end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus0.done === 1'b1) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got=%b exp=0", bus0.busy); end
    endtask

    task automatic test_overflow();
        logic [13:0] vals [3];
        logic [15:0] exps [3];
        logic        ovfs [3];
        int          lat;
        logic [15:0] bcd;
        logic        ovf;
        vals[0] = 14'd9999;  exps[0] = 16'h9999; ovfs[0] = 1'b0;
        vals[1] = 14'd10000; exps[1] = 16'h9999; ovfs[1] = 1'b1;
        vals[2] = 14'd1000;  exps[2] = 16'h1000; ovfs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run1(vals[i], lat, bcd, ovf);
            checks++; if (lat != 14) begin errors++; $display("FAIL ovf_latency[%0d] got=%0d exp=14", i, lat); end
            checks++; if (bcd !== exps[i]) begin errors++; $display("FAIL ovf_bcd[%0d] got=%h exp=%h", i, bcd, exps[i]); end
            checks++; if (ovf !== ovfs[i]) begin errors++; $display("FAIL ovf_flag[%0d] got=%b exp=%b", i, ovf, ovfs[i]); end
        end
    endtask

`ifdef BIN_TO_BCD_SIGNED_EN
    task automatic test_signed();
        logic [12:0] vals [3];
        logic [15:0] exps [3];
        logic        negs [3];
        int          lat, busy_cyc;
        logic [15:0] bcd;
        logic        ovf;
        vals[0] = 13'h1000;  exps[0] = 16'h4096; negs[0] = 1'b1;
        vals[1] = 13'h1FFF;  exps[1] = 16'h0001; negs[1] = 1'b1;
        vals[2] = 13'd100;   exps[2] = 16'h0100; negs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run0(vals[i], lat, busy_cyc, bcd, ovf);
            checks++; if (bcd !== exps[i]) begin errors++; $display("FAIL signed_bcd[%0d] got=%h exp=%h", i, bcd, exps[i]); end
            checks++; if (bus0.negative !== negs[i]) begin errors++; $display("FAIL signed_neg[%0d] got=%b exp=%b", i, bus0.negative, negs[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_start_while_busy();
        test_reset_abort();
`ifdef BIN_TO_BCD_SIGNED_EN
        test_signed();
`else
        test_overflow();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
